// File: rtl/bcd_to_bin_pkg.sv
// rtl/bcd_to_bin_pkg.sv - shared state encoding and width helper for the BCD/binary converters
package bcd_to_bin_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_CONV = 1'b1
    } state_t;

    localparam int BCD_MAX_DIGIT = 9;

    // Smallest binary width able to hold 10^digits - 1.
    function automatic int min_bin_w(input int digits);
        longint unsigned max_val;
        int w;
        max_val = 64'd1;
        for (int i = 0; i < digits; i++) begin
            max_val = max_val * 64'd10;
        end
        max_val = max_val - 64'd1;
        w = 0;
        for (int b = 0; b < 64; b++) begin
            if (max_val != 64'd0) begin
                w++;
                max_val = max_val >> 1;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/bcd_mac10.sv
// rtl/bcd_mac10.sv - combinational acc*10 + digit step with digit legality flag
module bcd_mac10
    import bcd_to_bin_pkg::*;
#(
    parameter int BIN_W = 14
) (
    input  logic [BIN_W-1:0] acc,
    input  logic [3:0]       digit,
    output logic [BIN_W-1:0] acc_next,
    output logic             digit_ok
);

    // Shift/add form keeps the step multiplier-free.
    assign acc_next = (acc << 3) + (acc << 1) + BIN_W'(digit);
    assign digit_ok = (digit <= 4'(BCD_MAX_DIGIT));

endmodule

// File: rtl/bcd_to_bin.sv
// rtl/bcd_to_bin.sv - sequential BCD to binary converter, one digit per clock, MSD first
module bcd_to_bin
    import bcd_to_bin_pkg::*;
#(
    parameter int DIGITS = 4,
    parameter int BIN_W  = 14
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   bcd_in,
    output logic                  busy,
    output logic                  done,
    output logic [BIN_W-1:0]      result,
    output logic                  err
);

    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    generate
        if (DIGITS < 1 || DIGITS > 8) begin : g_digits_check
            $error("bcd_to_bin: DIGITS must be within 1..8");
        end
        if (BIN_W < min_bin_w(DIGITS)) begin : g_bin_w_check
            $error("bcd_to_bin: BIN_W too small to hold 10^DIGITS-1");
        end
    endgenerate

    state_t               state;
    logic [4*DIGITS-1:0]  shadow;
    logic [BIN_W-1:0]     acc;
    logic [IDX_W-1:0]     idx;
    logic                 bad;
    logic [3:0]           cur_digit;
    logic [BIN_W-1:0]     acc_next;
    logic                 digit_ok;

    always_comb begin
        cur_digit = 4'd0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx == IDX_W'(i)) begin
                cur_digit = shadow[4*i +: 4];
            end
        end
    end

    bcd_mac10 #(
        .BIN_W (BIN_W)
    ) u_mac10 (
        .acc      (acc),
        .digit    (cur_digit),
        .acc_next (acc_next),
        .digit_ok (digit_ok)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            shadow <= '0;
            acc    <= '0;
            idx    <= '0;
            bad    <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
            err    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        shadow <= bcd_in;
                        acc    <= '0;
                        idx    <= IDX_W'(DIGITS - 1);
                        bad    <= 1'b0;
                        busy   <= 1'b1;
                        state  <= ST_CONV;
                    end
                end
                ST_CONV: begin
                    if (idx == '0) begin
                        // Any illegal digit zeroes the result but keeps the full conversion length.
                        result <= (bad || !digit_ok) ? '0 : acc_next;
                        err    <= bad || !digit_ok;
                        done   <= 1'b1;
                        busy   <= 1'b0;
                        state  <= ST_IDLE;
                    end else begin
                        acc <= acc_next;
                        bad <= bad || !digit_ok;
                        idx <= idx - 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_to_bin.sv
// tb/tb_bcd_to_bin.sv - scoreboard bench for bcd_to_bin
module tb_bcd_to_bin;

    localparam int DIGITS = 4;
    localparam int BIN_W  = 14;

    typedef struct {
        logic [BIN_W-1:0] res;
        logic             err;
        int               done_cyc;
    } exp_t;

    logic                 clk;
    logic                 rst_n;
    logic                 start;
    logic [4*DIGITS-1:0]  bcd_in;
    logic                 busy;
    logic                 done;
    logic [BIN_W-1:0]     result;
    logic                 err;

    exp_t sb[$];
    int   checks;
    int   errors;
    int   cyc;

    bcd_to_bin #(
        .DIGITS (DIGITS),
        .BIN_W  (BIN_W)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .bcd_in (bcd_in),
        .busy   (busy),
        .done   (done),
        .result (result),
        .err    (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic exp_t model(input logic [4*DIGITS-1:0] bcd, input int done_cyc);
        exp_t e;
        int   val;
        logic bad;
        logic [3:0] d;
        val = 0;
        bad = 1'b0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            d = bcd[4*i +: 4];
            if (d > 4'd9) bad = 1'b1;
            val = val * 10 + int'(d);
        end
        e.res      = bad ? '0 : BIN_W'(val);
        e.err      = bad;
        e.done_cyc = done_cyc;
        return e;
    endfunction

    // Output side: every done pops one expectation, including its arrival cycle.
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (sb.size() == 0) begin
                check_val("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check_val("result", 32'(result), 32'(e.res));
                check_val("err", 32'(err), 32'(e.err));
                check_val("latency", 32'(cyc), 32'(e.done_cyc));
            end
        end
    end

    // Called at a negedge; the start edge is the next posedge.
    task automatic drive(input logic [4*DIGITS-1:0] bcd);
        start  = 1'b1;
        bcd_in = bcd;
        sb.push_back(model(bcd, cyc + 1 + DIGITS));
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            check_val("timeout", 32'(sb.size()), 32'd0);
            sb.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        cyc    = 0;
        rst_n  = 1'b0;
        start  = 1'b0;
        bcd_in = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Idle after reset
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check_val("idle", {busy, done, result, err}, 32'd0);
        end

        // 1234 with busy window
        drive(16'h1234);
        for (int i = 0; i < DIGITS - 1; i++) begin
            check_val("busy_conv", 32'(busy), 32'd1);
            @(negedge clk);
        end
        check_val("busy_conv", 32'(busy), 32'd1);
        @(negedge clk);
        check_val("busy_done", 32'(busy), 32'd0);
        check_val("done_seen", 32'(done), 32'd1);
        wait_idle();

        // 9999 then start on the done cycle with 0000
        drive(16'h9999);
        repeat (DIGITS) @(negedge clk);
        check_val("done_b2b", 32'(done), 32'd1);
        drive(16'h0000);
        wait_idle();

        // Illegal digit, then legal follow-up
        drive(16'h12A4);
        wait_idle();
        drive(16'h0042);
        wait_idle();

        // Start pulses while busy are ignored; bcd_in changes after start edge
        drive(16'h0057);
        bcd_in = 16'h9999;
        start  = 1'b1;
        repeat (2) @(negedge clk);
        start = 1'b0;
        wait_idle();

        // Held start restarts after every done
        start  = 1'b1;
        bcd_in = 16'h0815;
        for (int j = 0; j < 3; j++) begin
            sb.push_back(model(16'h0815, cyc + 1 + DIGITS + j * (DIGITS + 1)));
        end
        repeat (2 * (DIGITS + 1) + 1) @(negedge clk);
        start = 1'b0;
        wait_idle();

        // Random mix, some with illegal nibbles
        for (int j = 0; j < 6; j++) begin
            logic [4*DIGITS-1:0] v;
            for (int k = 0; k < DIGITS; k++) begin
                v[4*k +: 4] = 4'($urandom_range(0, 11));
            end
            drive(v);
            repeat (DIGITS) @(negedge clk);
        end
        wait_idle();

        // Async reset mid-conversion aborts without done
        drive(16'h5555);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_val("reset_abort", {busy, done, result, err}, 32'd0);
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (DIGITS + 2) @(negedge clk);
        check_val("no_done_after_abort", {busy, done, result, err}, 32'd0);
        drive(16'h0007);
        wait_idle();

        check_val("sb_empty", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
